pipe_skid_stage: RTL and testbench

//  Generic inter-stage pipeline register with a valid/ready handshake and a
//  2-entry skid buffer; successor to the fixed 64-bit enable-only IF/ID latch.

---
 rtl/pipe_pkg.sv | 27 ++
 rtl/pipe_skid_stage_sat_counter.sv | 38 +++
 rtl/pipe_skid_stage.sv | 145 ++++++++++++++
 tb/tb_pipe_skid_stage.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Package     : pipe_pkg
// Description : Shared types and constants for the inter-stage pipeline
//               registers: occupancy state encoding, the NOP bubble pattern
//               and the in_ready decode helper.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

  // Occupancy of the stage; encoding 2'd3 is unused and treated as EMPTY.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  // All-zero word decodes as a MIPS NOP (sll $0,$0,0).
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // The stage can take a new entry unless both slots are occupied.
  function automatic logic ready_for(input state_t s);
    return (s != ST_TWO);
  endfunction

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/pipe_skid_stage_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that sticks at its maximum value instead of
//               wrapping. clr takes priority over inc.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] q
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear, hold at all-ones, or step by one.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign q = cnt_q;

endmodule : sat_counter
`default_nettype wire

// File: rtl/pipe_skid_stage.sv
`default_nettype none
// ============================================================================
// Module      : pipe_skid_stage
// Description : Inter-stage pipeline register with valid/ready handshake and
//               a two-entry skid buffer. in_ready is registered so there is
//               no combinational path from out_ready to in_ready. Supports
//               flush-to-bubble and saturating stall/flush counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = 64,
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(NOP_INSTR),
  parameter int               CNT_W     = 16
) (
  input  logic             reloj,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  state_t           state_q,      state_d;
  logic [WIDTH-1:0] main_data_q,  main_data_d;
  logic             main_valid_q, main_valid_d;
  logic [WIDTH-1:0] skid_data_q,  skid_data_d;
  logic             skid_valid_q, skid_valid_d;
  logic             in_ready_q,   in_ready_d;

  logic accept;
  logic pop;

  assign accept = in_valid & in_ready_q;
  assign pop    = main_valid_q & out_ready;

  // Occupancy transitions; flush overrides everything except reset.
  always_comb begin
    state_d      = state_q;
    main_data_d  = main_data_q;
    main_valid_d = main_valid_q;
    skid_data_d  = skid_data_q;
    skid_valid_d = skid_valid_q;

    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          main_data_d  = in_data;
          main_valid_d = 1'b1;
          state_d      = ST_ONE;
        end
      end
      ST_ONE: begin
        if (pop && accept) begin
          // Back-to-back replace keeps full throughput with no bubble.
          main_data_d = in_data;
        end else if (pop) begin
          main_data_d  = RESET_VAL;
          main_valid_d = 1'b0;
          state_d      = ST_EMPTY;
        end else if (accept) begin
          // in_ready was already high, so the beat lands in the skid slot.
          skid_data_d  = in_data;
          skid_valid_d = 1'b1;
          state_d      = ST_TWO;
        end
      end
      ST_TWO: begin
        if (pop) begin
          main_data_d  = skid_data_q;
          skid_data_d  = RESET_VAL;
          skid_valid_d = 1'b0;
          state_d      = ST_ONE;
        end
      end
      default: begin
        // Unused encoding recovers to an empty, bubble-driving stage.
        state_d      = ST_EMPTY;
        main_data_d  = RESET_VAL;
        main_valid_d = 1'b0;
        skid_data_d  = RESET_VAL;
        skid_valid_d = 1'b0;
      end
    endcase

    if (flush) begin
      state_d      = ST_EMPTY;
      main_data_d  = RESET_VAL;
      main_valid_d = 1'b0;
      skid_data_d  = RESET_VAL;
      skid_valid_d = 1'b0;
    end

    in_ready_d = ready_for(state_d);
  end

  // State, payload and registered in_ready.
  always_ff @(posedge reloj) begin
    if (reset) begin
      state_q      <= ST_EMPTY;
      main_data_q  <= RESET_VAL;
      main_valid_q <= 1'b0;
      skid_data_q  <= RESET_VAL;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      main_data_q  <= main_data_d;
      main_valid_q <= main_valid_d;
      skid_data_q  <= skid_data_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = main_valid_q;
  assign out_data  = main_data_q;

  // skid_valid_q mirrors state==TWO; kept as an explicit register for debug.
  logic unused_skid_valid;
  assign unused_skid_valid = skid_valid_q;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (reloj),
    .clr (reset),
    .inc (main_valid_q & ~out_ready),
    .q   (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk (reloj),
    .clr (reset),
    .inc (flush),
    .q   (flush_cnt)
  );

endmodule : pipe_skid_stage
`default_nettype wire

// File: tb/tb_pipe_skid_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_skid_stage
// Description : Self-checking bench for pipe_skid_stage. A queue-based model
//               of the stage is advanced every clock and compared with the
//               DUT, alongside directed scenario checks and a random phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_skid_stage;

  localparam int          WIDTH = 64;
  localparam int          CNT_W = 4;
  localparam int unsigned CMAX  = (1 << CNT_W) - 1;

  logic             reloj;
  logic             reset;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  pipe_skid_stage #(
    .WIDTH     (WIDTH),
    .RESET_VAL ('0),
    .CNT_W     (CNT_W)
  ) dut (
    .reloj     (reloj),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );

  initial reloj = 1'b0;
  always #5 reloj = ~reloj;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a FIFO of at most two entries plus counters.
  logic [WIDTH-1:0] mq[$];
  bit               m_ready = 1'b1;
  int unsigned      m_stall = 0;
  int unsigned      m_flush = 0;

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs,
                     input logic [WIDTH-1:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the model with the inputs as driven, clock the DUT, compare.
  task automatic step();
    int sz;
    bit acc;
    bit pop;
    sz  = mq.size();
    acc = in_valid && m_ready;
    pop = (sz > 0) && out_ready;
    if (reset) begin
      mq.delete();
      m_ready = 1'b1;
      m_stall = 0;
      m_flush = 0;
    end else begin
      if ((sz > 0) && !out_ready && (m_stall < CMAX)) m_stall++;
      if (flush && (m_flush < CMAX)) m_flush++;
      if (flush) begin
        mq.delete();
        m_ready = 1'b1;
      end else begin
        if (pop) void'(mq.pop_front());
        if (acc) mq.push_back(in_data);
        m_ready = (mq.size() < 2);
      end
    end
    @(posedge reloj);
    #1;
    chk("out_valid", {63'd0, out_valid}, {63'd0, (mq.size() > 0)});
    chk("out_data",  out_data, (mq.size() > 0) ? mq[0] : '0);
    chk("in_ready",  {63'd0, in_ready}, {63'd0, m_ready});
    chk("stall_cnt", {60'd0, stall_cnt}, WIDTH'(m_stall));
    chk("flush_cnt", {60'd0, flush_cnt}, WIDTH'(m_flush));
  endtask

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    // 1. Reset state
    step();
    step();
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_in_ready",  {63'd0, in_ready},  64'd1);
    chk("rst_out_data",  out_data,           64'd0);
    chk("rst_stall",     {60'd0, stall_cnt}, 64'd0);
    chk("rst_flush",     {60'd0, flush_cnt}, 64'd0);
    reset = 1'b0;

    // 2. Streaming at full rate
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 64'h11 + 64'(i);
      step();
      chk("stream_data",  out_data, 64'h11 + 64'(i));
      chk("stream_valid", {63'd0, out_valid}, 64'd1);
    end
    in_valid = 1'b0;
    step();
    chk("stream_stall", {60'd0, stall_cnt}, 64'd0);

    // 3. Backpressure fills the skid slot
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'hA;
    step();
    in_data = 64'hB;
    step();
    chk("full_in_ready", {63'd0, in_ready}, 64'd0);
    in_valid = 1'b1;
    in_data  = 64'hBAD;
    for (int i = 0; i < 3; i++) step();
    in_valid = 1'b0;
    chk("hold_stall", {60'd0, stall_cnt}, 64'd4);
    chk("hold_head",  out_data, 64'hA);
    out_ready = 1'b1;
    step();
    chk("drain_b",        out_data, 64'hB);
    chk("drain_in_ready", {63'd0, in_ready}, 64'd1);
    step();
    chk("drain_empty", {63'd0, out_valid}, 64'd0);

    // 4. Flush from TWO with a simultaneous offer
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'h1;
    step();
    in_data = 64'h2;
    step();
    flush   = 1'b1;
    in_data = 64'hC;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_valid", {63'd0, out_valid}, 64'd0);
    chk("flush_data",  out_data,           64'd0);
    chk("flush_ready", {63'd0, in_ready},  64'd1);
    chk("flush_cnt1",  {60'd0, flush_cnt}, 64'd1);
    out_ready = 1'b1;
    step();
    chk("flush_no_c", {63'd0, out_valid}, 64'd0);

    // 5. Pop and accept in ONE replace the head without a bubble
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'hD;
    step();
    out_ready = 1'b1;
    in_data   = 64'hE;
    step();
    chk("replace_data",  out_data, 64'hE);
    chk("replace_valid", {63'd0, out_valid}, 64'd1);
    chk("replace_ready", {63'd0, in_ready}, 64'd1);
    in_valid = 1'b0;
    step();

    // 6. Stall counter saturation, then reset clears it
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'h5A;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) step();
    chk("stall_sat", {60'd0, stall_cnt}, 64'd15);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("stall_rst", {60'd0, stall_cnt}, 64'd0);

    // 7. Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = {$urandom, $urandom};
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      reset     = ($urandom_range(0, 99) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_pipe_skid_stage
`default_nettype wire
